ring_phase_monitor: RTL and testbench
=====================================

RING_PHASE_MONITOR -- requirements
Module: ring_phase_monitor

Interface
REQ-001 SHALL have: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have: ring_in  input  4  one-hot phase vector from the upstream ring counter; legal rotation 0001->0010->0100->1000->0001.
REQ-004 SHALL have: clr_err  input  1  synchronous fault clear, level-sampled.
REQ-005 SHALL have: phase  output  2  binary index of the accepted one-hot sample: 0001=0, 0010=1, 0100=2, 1000=3.
REQ-006 SHALL have: phase_valid  output  1  high when the current sample is one-hot.
REQ-007 SHALL have: locked  output  1  high in state LOCKED only.
REQ-008 SHALL have: rev_tick  output  1  one-cycle pulse per completed revolution while LOCKED.
REQ-009 SHALL have: rev_count  output  8  completed revolutions since lock; wraps 255->0.
REQ-010 SHALL have: fault  output  1  high in state FAULT only.
REQ-011 SHALL have: fault_code  output  2  00 none, 01 not one-hot, 10 out of order, 11 stall.

Function
REQ-012 All outputs SHALL be registered; a ring_in value sampled at edge n SHALL be reflected on outputs after edge n.
REQ-013 The block SHALL store the previous sample (prev) and compare each new sample against rotate-left(prev).
REQ-014 phase SHALL hold its last value when the sample is not one-hot; phase_valid SHALL be 0 for 0000 or any multi-hot value.
REQ-015 FSM states SHALL be UNLOCKED, SYNCING, LOCKED, FAULT.
REQ-016 UNLOCKED: one-hot sample -> SYNCING with sync count 0; otherwise stay.
REQ-017 SYNCING: correct rotation increments sync count; on the 4th consecutive correct rotation -> LOCKED; any non-one-hot or wrong rotation -> UNLOCKED (no fault raised).
REQ-018 LOCKED: non-one-hot sample -> FAULT, code 01; one-hot but not rotate-left(prev) and not equal to prev -> FAULT, code 10.
REQ-019 LOCKED: sample equal to prev SHALL be handled per REQ-029/REQ-030.
REQ-020 LOCKED: transition 1000->0001 SHALL pulse rev_tick for exactly one cycle and increment rev_count by 1 in that same cycle.
REQ-021 Entry into LOCKED SHALL clear rev_count to 0; the entry transition itself SHALL NOT pulse rev_tick.
REQ-022 FAULT: outputs fault=1, locked=0; fault_code and rev_count frozen; stays until clr_err=1, then -> UNLOCKED with fault_code=00.
REQ-023 clr_err in any state other than FAULT SHALL have no effect.
REQ-024 Simultaneous fault condition and clr_err in LOCKED: fault SHALL take priority (enter FAULT); clr_err is acted on only when already in FAULT.

Reset
REQ-025 rst=1 SHALL immediately force state UNLOCKED, prev=0000, phase=0, phase_valid=0, locked=0, rev_tick=0, rev_count=0, fault=0, fault_code=00.
REQ-026 Reset asserted mid-operation (any state) SHALL produce the REQ-025 values without waiting for a clock edge.
REQ-027 First edge after rst deasserts SHALL treat prev=0000 as having no predecessor (no rotation check; REQ-016 applies).

Configuration
REQ-028 Macro RING_MON_HOLD_EN SHALL select stall handling.
REQ-029 With RING_MON_HOLD_EN defined: a sample equal to prev is legal in SYNCING and LOCKED, leaves state, sync count and rev_count unchanged.
REQ-030 Without RING_MON_HOLD_EN: a sample equal to prev in LOCKED -> FAULT, code 11; in SYNCING -> UNLOCKED.

Verification
REQ-031 rst=1 two cycles then ring_in steps 0001,0010,0100,1000,0001 each cycle -> locked=1 after 5th sample edge, rev_count=0, fault=0.
REQ-032 Locked, run 3 full revolutions -> rev_tick pulses 3 times, one cycle each, on each 1000->0001, rev_count=3.
REQ-033 Locked at 0010, drive 0110 -> fault=1, fault_code=01, phase stays 1, phase_valid=0; assert clr_err one cycle -> fault=0, locked=0, state UNLOCKED.
REQ-034 Locked at 0010, drive 1000 -> fault=1, fault_code=10; rev_count frozen.
REQ-035 Locked at 0100, repeat 0100 -> with RING_MON_HOLD_EN: locked stays 1, no tick; without: fault_code=11.
REQ-036 Locked with rev_count=255, complete one revolution -> rev_count=0, rev_tick=1; then assert rst mid-cycle -> all outputs at REQ-025 values before next edge.

Source files
------------

// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: watches a 4-bit one-hot ring counter and tracks its phase.
// The block acquires lock after four consecutive correct rotations, counts
// completed revolutions while locked, and latches a fault code on a bad sample.
//
// Build option: define RING_MON_HOLD_EN to accept a repeated sample (ring
// stall) as legal in SYNCING and LOCKED. Without it, a repeat drops SYNCING
// back to UNLOCKED and raises a stall fault (code 11) in LOCKED.
//
// fsm_state is a debug view of the FSM register:
// 0 UNLOCKED, 1 SYNCING, 2 LOCKED, 3 FAULT.
//
// ring_in has no handshake: one sample is taken on every rising clock edge.
// clr_err is level-sampled on the same edge and acts only in FAULT.

module ring_phase_monitor (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ring_in,
  input  logic       clr_err,
  output logic [1:0] phase,
  output logic       phase_valid,
  output logic       locked,
  output logic       rev_tick,
  output logic [7:0] rev_count,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SYNCING  = 2'd1,
    LOCKED   = 2'd2,
    FAULT    = 2'd3
  } state_t;

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_NOT1H = 2'b01;
  localparam logic [1:0] CODE_ORDER = 2'b10;
  localparam logic [1:0] CODE_STALL = 2'b11;

  state_t     state, next_state;
  logic [3:0] prev;
  logic [1:0] sync_cnt, next_sync;
  logic [7:0] next_rev;
  logic       next_tick;
  logic [1:0] next_code;
  logic [1:0] next_phase;

  logic       one_hot;
  logic       is_rot;
  logic       is_same;

  // Classify the incoming sample against the previous one.
  always_comb begin
    one_hot = $onehot(ring_in);
    is_rot  = (ring_in == {prev[2:0], prev[3]});
    is_same = (ring_in == prev);
  end

  // Binary index of the sample; holds the last value when not one-hot.
  always_comb begin
    next_phase = phase;
    case (ring_in)
      4'b0001: next_phase = 2'd0;
      4'b0010: next_phase = 2'd1;
      4'b0100: next_phase = 2'd2;
      4'b1000: next_phase = 2'd3;
      default: next_phase = phase;
    endcase
  end

  // Next-state logic plus the values that follow the state transition.
  always_comb begin
    next_state = state;
    next_sync  = sync_cnt;
    next_rev   = rev_count;
    next_tick  = 1'b0;
    next_code  = fault_code;
    case (state)
      UNLOCKED: begin
        // No predecessor is checked here, including right after reset.
        if (one_hot) begin
          next_state = SYNCING;
          next_sync  = 2'd0;
        end
      end
      SYNCING: begin
        if (one_hot && is_rot) begin
          if (sync_cnt == 2'd3) begin
            next_state = LOCKED;
            next_rev   = 8'd0;
          end else begin
            next_sync = sync_cnt + 2'd1;
          end
        end else if (one_hot && is_same) begin
`ifdef RING_MON_HOLD_EN
          next_state = SYNCING;
`else
          next_state = UNLOCKED;
`endif
        end else begin
          next_state = UNLOCKED;
        end
      end
      LOCKED: begin
        // Fault detection wins over clr_err, which is ignored here.
        if (!one_hot) begin
          next_state = FAULT;
          next_code  = CODE_NOT1H;
        end else if (is_rot) begin
          if (prev == 4'b1000) begin
            next_tick = 1'b1;
            next_rev  = rev_count + 8'd1;
          end
        end else if (is_same) begin
`ifdef RING_MON_HOLD_EN
          next_state = LOCKED;
`else
          next_state = FAULT;
          next_code  = CODE_STALL;
`endif
        end else begin
          next_state = FAULT;
          next_code  = CODE_ORDER;
        end
      end
      FAULT: begin
        if (clr_err) begin
          next_state = UNLOCKED;
          next_code  = CODE_NONE;
        end
      end
      default: next_state = UNLOCKED;
    endcase
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= UNLOCKED;
      prev        <= 4'b0000;
      sync_cnt    <= 2'd0;
      phase       <= 2'd0;
      phase_valid <= 1'b0;
      rev_tick    <= 1'b0;
      rev_count   <= 8'd0;
      fault_code  <= CODE_NONE;
    end else begin
      state       <= next_state;
      prev        <= ring_in;
      sync_cnt    <= next_sync;
      phase       <= next_phase;
      phase_valid <= one_hot;
      rev_tick    <= next_tick;
      rev_count   <= next_rev;
      fault_code  <= next_code;
    end
  end

  // Status flags decoded straight from the state register.
  always_comb begin
    locked    = (state == LOCKED);
    fault     = (state == FAULT);
    fsm_state = state;
  end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb_ring_phase_monitor: directed vectors with hand-computed expectations
// for ring_phase_monitor. Build with or without RING_MON_HOLD_EN.

module tb_ring_phase_monitor;

  localparam logic [1:0] S_UNLOCKED = 2'd0;
  localparam logic [1:0] S_SYNCING  = 2'd1;
  localparam logic [1:0] S_LOCKED   = 2'd2;
  localparam logic [1:0] S_FAULT    = 2'd3;

  logic       clk;
  logic       rst;
  logic [3:0] ring_in;
  logic       clr_err;
  logic [1:0] phase;
  logic       phase_valid;
  logic       locked;
  logic       rev_tick;
  logic [7:0] rev_count;
  logic       fault;
  logic [1:0] fault_code;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;
  int tick_seen;
  logic [7:0] exp_q[$];
  logic [7:0] exp_rev;

  ring_phase_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .ring_in    (ring_in),
    .clr_err    (clr_err),
    .phase      (phase),
    .phase_valid(phase_valid),
    .locked     (locked),
    .rev_tick   (rev_tick),
    .rev_count  (rev_count),
    .fault      (fault),
    .fault_code (fault_code),
    .fsm_state  (fsm_state)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one sample, let one rising edge take it, sample outputs 1 ns later.
  task automatic drive(input logic [3:0] v);
    ring_in = v;
    @(posedge clk);
    #1;
  endtask

  // Reach LOCKED from UNLOCKED or SYNCING: 0000 forces UNLOCKED first.
  task automatic relock();
    drive(4'b0000);
    drive(4'b0001);
    drive(4'b0010);
    drive(4'b0100);
    drive(4'b1000);
    drive(4'b0001);
  endtask

  task automatic clear_fault();
    clr_err = 1'b1;
    drive(4'b0000);
    clr_err = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_phase"}, phase, 0);
    check({tag, "_pvalid"}, phase_valid, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_tick"}, rev_tick, 0);
    check({tag, "_revcnt"}, rev_count, 0);
    check({tag, "_fault"}, fault, 0);
    check({tag, "_code"}, fault_code, 0);
    check({tag, "_state"}, fsm_state, S_UNLOCKED);
  endtask

  initial begin
    rst = 1'b1;
    ring_in = 4'b0000;
    clr_err = 1'b0;
    #1;
    check_reset_values("rst_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_values("rst_hold");
    rst = 1'b0;

    // Acquisition: four correct rotations after the first one-hot sample.
    drive(4'b0001);
    check("acq1_state", fsm_state, S_SYNCING);
    check("acq1_phase", phase, 0);
    check("acq1_pvalid", phase_valid, 1);
    drive(4'b0010);
    drive(4'b0100);
    drive(4'b1000);
    check("acq4_locked", locked, 0);
    check("acq4_phase", phase, 3);
    drive(4'b0001);
    check("acq5_locked", locked, 1);
    check("acq5_revcnt", rev_count, 0);
    check("acq5_tick", rev_tick, 0);
    check("acq5_fault", fault, 0);

    // Three full revolutions; expected counts come from the queue.
    for (int r = 1; r <= 3; r++) exp_q.push_back(8'(r));
    tick_seen = 0;
    for (int r = 0; r < 3; r++) begin
      drive(4'b0010);
      check("rev_notick_a", rev_tick, 0);
      drive(4'b0100);
      drive(4'b1000);
      check("rev_notick_b", rev_tick, 0);
      drive(4'b0001);
      if (rev_tick) tick_seen++;
      exp_rev = exp_q.pop_front();
      check("rev_count_step", rev_count, exp_rev);
    end
    check("rev_ticks", tick_seen, 3);
    drive(4'b0010);
    check("tick_one_cycle", rev_tick, 0);
    check("rev_count3", rev_count, 3);

    // Not one-hot while locked at 0010.
    drive(4'b0110);
    check("nh_fault", fault, 1);
    check("nh_code", fault_code, 1);
    check("nh_phase", phase, 1);
    check("nh_pvalid", phase_valid, 0);
    check("nh_locked", locked, 0);
    check("nh_revcnt", rev_count, 3);
    clr_err = 1'b1;
    drive(4'b0110);
    clr_err = 1'b0;
    check("clr_fault", fault, 0);
    check("clr_locked", locked, 0);
    check("clr_code", fault_code, 0);
    check("clr_state", fsm_state, S_UNLOCKED);

    // Wrong rotation while syncing drops to UNLOCKED without a fault.
    drive(4'b0001);
    drive(4'b0010);
    drive(4'b1000);
    check("sync_bad_state", fsm_state, S_UNLOCKED);
    check("sync_bad_fault", fault, 0);

    // Out-of-order sample while locked; rev_count frozen afterwards.
    relock();
    drive(4'b0010);
    drive(4'b0100);
    drive(4'b1000);
    drive(4'b0001);
    check("ooo_pre_revcnt", rev_count, 1);
    drive(4'b0010);
    drive(4'b1000);
    check("ooo_fault", fault, 1);
    check("ooo_code", fault_code, 2);
    check("ooo_revcnt", rev_count, 1);
    drive(4'b0001);
    check("frz_revcnt", rev_count, 1);
    check("frz_tick", rev_tick, 0);
    check("frz_code", fault_code, 2);
    check("frz_state", fsm_state, S_FAULT);
    clear_fault();
    check("ooo_clr_state", fsm_state, S_UNLOCKED);

    // clr_err outside FAULT is ignored; fault beats clr_err in LOCKED.
    relock();
    clr_err = 1'b1;
    drive(4'b0010);
    check("clr_locked_noeff", locked, 1);
    drive(4'b0000);
    check("clr_prio_fault", fault, 1);
    check("clr_prio_code", fault_code, 1);
    clr_err = 1'b0;
    drive(4'b0000);
    check("clr_prio_hold", fault, 1);
    clear_fault();

    // Repeated sample in SYNCING.
    drive(4'b0001);
    drive(4'b0010);
    drive(4'b0010);
`ifdef RING_MON_HOLD_EN
    check("sync_rep_state", fsm_state, S_SYNCING);
`else
    check("sync_rep_state", fsm_state, S_UNLOCKED);
`endif

    // Repeated sample while locked at 0100.
    relock();
    drive(4'b0010);
    drive(4'b0100);
    drive(4'b0100);
`ifdef RING_MON_HOLD_EN
    check("hold_locked", locked, 1);
    check("hold_tick", rev_tick, 0);
    check("hold_code", fault_code, 0);
    drive(4'b1000);
    drive(4'b0001);
    check("hold_rev_tick", rev_tick, 1);
    check("hold_revcnt", rev_count, 1);
`else
    check("stall_fault", fault, 1);
    check("stall_code", fault_code, 3);
    check("stall_locked", locked, 0);
`endif

    // Clean restart, then wrap rev_count past 255.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    relock();
    for (int r = 0; r < 255; r++) begin
      drive(4'b0010);
      drive(4'b0100);
      drive(4'b1000);
      drive(4'b0001);
    end
    check("wrap_pre_revcnt", rev_count, 255);
    drive(4'b0010);
    drive(4'b0100);
    drive(4'b1000);
    drive(4'b0001);
    check("wrap_revcnt", rev_count, 0);
    check("wrap_tick", rev_tick, 1);
    check("wrap_locked", locked, 1);

    // Reset mid-cycle, checked before the next rising edge.
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog keeps the run bounded.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
